// File: rtl/sketch_cursor_ctrl_if.sv
// Frame-buffer write port: valid/ready pixel write carrying {y, x} address and colour.
interface sketch_cursor_ctrl_if #(
  parameter int AW = 14,
  parameter int CB = 3
) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [CB-1:0] wr_data;
  logic          wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/sketch_cursor_ctrl.sv
// Etch-a-sketch cursor/pen controller: rate-limited cursor steps, pixel draw/erase, full clear.
// Optional macro CURSOR_WRAP_EN: cursor wraps at canvas edges instead of clamping.
module sketch_cursor_ctrl #(
  parameter int XB       = 7,
  parameter int YB       = 7,
  parameter int CB       = 3,
  parameter int MOVE_DIV = 500000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up_i,
  input  logic                  btn_down_i,
  input  logic                  btn_left_i,
  input  logic                  btn_right_i,
  input  logic [1:0]            pen_mode_i,
  input  logic [CB-1:0]         sw_i,
  sketch_cursor_ctrl_if.master  wr,
  output logic [XB-1:0]         cur_x_o,
  output logic [YB-1:0]         cur_y_o,
  output logic                  busy_o
);

  localparam int AW    = XB + YB;
  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOVE_DIV - 1);
  localparam logic [XB-1:0]    X_MAX    = {XB{1'b1}};
  localparam logic [YB-1:0]    Y_MAX    = {YB{1'b1}};
  localparam logic [XB-1:0]    X_MIN    = {XB{1'b0}};
  localparam logic [YB-1:0]    Y_MIN    = {YB{1'b0}};
  localparam logic [XB-1:0]    X_MID    = XB'(1) << (XB - 1);
  localparam logic [YB-1:0]    Y_MID    = YB'(1) << (YB - 1);
  localparam logic [AW-1:0]    A_LAST   = {AW{1'b1}};

  localparam logic [1:0] PEN_DRAW  = 2'b01;
  localparam logic [1:0] PEN_ERASE = 2'b10;
  localparam logic [1:0] PEN_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WRITE    = 2'd1,
    S_CLEAR    = 2'd2,
    S_CLR_WAIT = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XB-1:0]    cur_x_q, cur_x_d;
  logic [YB-1:0]    cur_y_q, cur_y_d;
  logic             wr_en_q;
  logic [AW-1:0]    wr_addr_q;
  logic [CB-1:0]    wr_data_q;
  logic             busy_q;
  logic             step_s;
  logic             xfer_s;

  assign step_s = (cnt_q == CNT_LAST);
  assign xfer_s = wr_en_q & wr.wr_ready;

  // Free-running step divider; never stalls, whatever the FSM is doing.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (step_s) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Candidate x; edge test is done before the add so nothing overflows in clamp mode.
  always_comb begin
    cur_x_d = cur_x_q;
    if (btn_right_i && !btn_left_i) begin
`ifdef CURSOR_WRAP_EN
      cur_x_d = cur_x_q + XB'(1);
`else
      if (cur_x_q != X_MAX) cur_x_d = cur_x_q + XB'(1);
      else                  cur_x_d = cur_x_q;
`endif
    end else if (btn_left_i && !btn_right_i) begin
`ifdef CURSOR_WRAP_EN
      cur_x_d = cur_x_q - XB'(1);
`else
      if (cur_x_q != X_MIN) cur_x_d = cur_x_q - XB'(1);
      else                  cur_x_d = cur_x_q;
`endif
    end else begin
      cur_x_d = cur_x_q;
    end
  end

  // Candidate y, same rule as x.
  always_comb begin
    cur_y_d = cur_y_q;
    if (btn_down_i && !btn_up_i) begin
`ifdef CURSOR_WRAP_EN
      cur_y_d = cur_y_q + YB'(1);
`else
      if (cur_y_q != Y_MAX) cur_y_d = cur_y_q + YB'(1);
      else                  cur_y_d = cur_y_q;
`endif
    end else if (btn_up_i && !btn_down_i) begin
`ifdef CURSOR_WRAP_EN
      cur_y_d = cur_y_q - YB'(1);
`else
      if (cur_y_q != Y_MIN) cur_y_d = cur_y_q - YB'(1);
      else                  cur_y_d = cur_y_q;
`endif
    end else begin
      cur_y_d = cur_y_q;
    end
  end

  // Control FSM with registered cursor and write-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cur_x_q   <= X_MID;
      cur_y_q   <= Y_MID;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {AW{1'b0}};
      wr_data_q <= {CB{1'b0}};
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pen_mode_i == PEN_CLEAR) begin
            state_q   <= S_CLEAR;
            wr_en_q   <= 1'b1;
            wr_addr_q <= {AW{1'b0}};
            wr_data_q <= {CB{1'b0}};
            busy_q    <= 1'b1;
          end else if (step_s) begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            // A stationary cursor still paints, so the write ignores whether it moved.
            if ((pen_mode_i == PEN_DRAW) || (pen_mode_i == PEN_ERASE)) begin
              state_q   <= S_WRITE;
              wr_en_q   <= 1'b1;
              wr_addr_q <= {cur_y_d, cur_x_d};
              wr_data_q <= (pen_mode_i == PEN_DRAW) ? sw_i : {CB{1'b0}};
            end
          end
        end
        S_WRITE: begin
          if (xfer_s) begin
            wr_en_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (xfer_s) begin
            if (wr_addr_q == A_LAST) begin
              wr_en_q <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= S_CLR_WAIT;
            end else begin
              wr_addr_q <= wr_addr_q + AW'(1);
            end
          end
        end
        S_CLR_WAIT: begin
          if (pen_mode_i != PEN_CLEAR) state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          wr_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr.wr_en   = wr_en_q;
  assign wr.wr_addr = wr_addr_q;
  assign wr.wr_data = wr_data_q;
  assign cur_x_o    = cur_x_q;
  assign cur_y_o    = cur_y_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_sketch_cursor_ctrl.sv
// Directed bench for sketch_cursor_ctrl on an 8x8 canvas with a 4-cycle step period.
module tb_sketch_cursor_ctrl;

  localparam int XB = 3;
  localparam int YB = 3;
  localparam int CB = 3;
  localparam int MOVE_DIV = 4;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [3:0] B_NONE = 4'b0000;
  localparam logic [3:0] B_R    = 4'b0001;
  localparam logic [3:0] B_L    = 4'b0010;
  localparam logic [3:0] B_D    = 4'b0100;
  localparam logic [3:0] B_U    = 4'b1000;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] btn;
  logic [1:0] pen;
  logic [2:0] sw;
  logic rdy;
  logic [2:0] cur_x, cur_y;
  logic busy;

  int checks = 0;
  int errors = 0;
  int xfers = 0;
  logic [5:0] last_addr = 6'd0;
  logic [2:0] last_data = 3'd0;

  sketch_cursor_ctrl_if #(.AW(XB + YB), .CB(CB)) wr_if ();
  assign wr_if.wr_ready = rdy;

  sketch_cursor_ctrl #(.XB(XB), .YB(YB), .CB(CB), .MOVE_DIV(MOVE_DIV)) dut (
    .clk(clk), .reset(reset),
    .btn_up_i(btn[3]), .btn_down_i(btn[2]), .btn_left_i(btn[1]), .btn_right_i(btn[0]),
    .pen_mode_i(pen), .sw_i(sw), .wr(wr_if.master),
    .cur_x_o(cur_x), .cur_y_o(cur_y), .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so a handshake seen at negedge completes at the next posedge.
  always @(negedge clk) begin
    if (!reset && wr_if.wr_en && wr_if.wr_ready) begin
      xfers     <= xfers + 1;
      last_addr <= wr_if.wr_addr;
      last_data <= wr_if.wr_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [1:0] pen;
    logic [2:0] sw;
    logic [2:0] ex;
    logic [2:0] ey;
    logic       en;
    int         xf;
    logic [2:0] data;
  } vec_t;

  vec_t vecs [19];

  initial begin
    int n;
    int xf0;
    logic [5:0] pend_addr;
    logic [2:0] pend_data;
    logic [2:0] cx, cy, nx;
    logic [5:0] hold_addr;

    vecs[0]  = '{B_R,       2'b00, 3'd0, 3'd5,                  3'd4, 1'b0, 0, 3'd0};
    vecs[1]  = '{B_R,       2'b00, 3'd0, 3'd6,                  3'd4, 1'b0, 0, 3'd0};
    vecs[2]  = '{B_R,       2'b00, 3'd0, 3'd7,                  3'd4, 1'b0, 0, 3'd0};
    vecs[3]  = '{B_R,       2'b00, 3'd0, WRAP ? 3'd0 : 3'd7,    3'd4, 1'b0, 0, 3'd0};
    vecs[4]  = '{B_R,       2'b00, 3'd0, WRAP ? 3'd1 : 3'd7,    3'd4, 1'b0, 0, 3'd0};
    vecs[5]  = '{B_L | B_R, 2'b00, 3'd0, WRAP ? 3'd1 : 3'd7,    3'd4, 1'b0, 0, 3'd0};
    vecs[6]  = '{B_L,       2'b00, 3'd0, WRAP ? 3'd0 : 3'd6,    3'd4, 1'b0, 0, 3'd0};
    vecs[7]  = '{B_L,       2'b00, 3'd0, WRAP ? 3'd7 : 3'd5,    3'd4, 1'b0, 0, 3'd0};
    vecs[8]  = '{B_L,       2'b00, 3'd0, WRAP ? 3'd6 : 3'd4,    3'd4, 1'b0, 0, 3'd0};
    vecs[9]  = '{B_D | B_L, 2'b01, 3'd5, WRAP ? 3'd5 : 3'd3,    3'd5, 1'b1, 0, 3'd5};
    vecs[10] = '{B_NONE,    2'b00, 3'd5, WRAP ? 3'd5 : 3'd3,    3'd5, 1'b0, 1, 3'd0};
    vecs[11] = '{B_U | B_D, 2'b01, 3'd2, WRAP ? 3'd5 : 3'd3,    3'd5, 1'b1, 1, 3'd2};
    vecs[12] = '{B_NONE,    2'b00, 3'd2, WRAP ? 3'd5 : 3'd3,    3'd5, 1'b0, 2, 3'd0};
    vecs[13] = '{B_U,       2'b00, 3'd0, WRAP ? 3'd5 : 3'd3,    3'd4, 1'b0, 2, 3'd0};
    vecs[14] = '{B_U,       2'b00, 3'd0, WRAP ? 3'd5 : 3'd3,    3'd3, 1'b0, 2, 3'd0};
    vecs[15] = '{B_U,       2'b00, 3'd0, WRAP ? 3'd5 : 3'd3,    3'd2, 1'b0, 2, 3'd0};
    vecs[16] = '{B_U,       2'b00, 3'd0, WRAP ? 3'd5 : 3'd3,    3'd1, 1'b0, 2, 3'd0};
    vecs[17] = '{B_U,       2'b00, 3'd0, WRAP ? 3'd5 : 3'd3,    3'd0, 1'b0, 2, 3'd0};
    vecs[18] = '{B_U,       2'b00, 3'd0, WRAP ? 3'd5 : 3'd3,    WRAP ? 3'd7 : 3'd0, 1'b0, 2, 3'd0};

    reset = 1'b1; btn = B_NONE; pen = 2'b00; sw = 3'd0; rdy = 1'b1;
    pend_addr = 6'd0; pend_data = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", cur_x, 3'd4);
    chk("rst_y", cur_y, 3'd4);
    chk("rst_wr_en", wr_if.wr_en, 1'b0);
    chk("rst_addr", wr_if.wr_addr, 6'd0);
    chk("rst_data", wr_if.wr_data, 3'd0);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b0;

    // One step period per vector; the step lands on the last edge of each window.
    for (int i = 0; i < 19; i++) begin
      btn = vecs[i].btn; pen = vecs[i].pen; sw = vecs[i].sw; rdy = 1'b1;
      n = xfers;
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("v%0d_x", i), cur_x, vecs[i].ex);
      chk($sformatf("v%0d_y", i), cur_y, vecs[i].ey);
      chk($sformatf("v%0d_wr_en", i), wr_if.wr_en, vecs[i].en);
      chk($sformatf("v%0d_xfers", i), xfers, vecs[i].xf);
      if (xfers > n) begin
        chk($sformatf("v%0d_last_addr", i), last_addr, pend_addr);
        chk($sformatf("v%0d_last_data", i), last_data, pend_data);
      end
      if (vecs[i].en) begin
        pend_addr = {vecs[i].ey, vecs[i].ex};
        pend_data = vecs[i].data;
        chk($sformatf("v%0d_addr", i), wr_if.wr_addr, pend_addr);
        chk($sformatf("v%0d_data", i), wr_if.wr_data, pend_data);
      end
    end

    // Erase with a long stall; steps arriving during WRITE are dropped.
    cx = vecs[18].ex; cy = vecs[18].ey; nx = cx + 3'd1;
    hold_addr = {cy, nx};
    btn = B_R; pen = 2'b10; rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    xf0 = xfers;
    chk("er_wr_en", wr_if.wr_en, 1'b1);
    chk("er_x", cur_x, nx);
    chk("er_addr", wr_if.wr_addr, hold_addr);
    chk("er_data", wr_if.wr_data, 3'd0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_wr_en", k), wr_if.wr_en, 1'b1);
      chk($sformatf("stall%0d_addr", k), wr_if.wr_addr, hold_addr);
      chk($sformatf("stall%0d_x", k), cur_x, nx);
    end
    chk("stall_xfers", xfers, xf0);
    rdy = 1'b1; btn = B_NONE; pen = 2'b00;
    @(posedge clk); #1;
    chk("er_done_wr_en", wr_if.wr_en, 1'b0);
    chk("er_xfers", xfers, xf0 + 1);
    chk("er_last_addr", last_addr, hold_addr);
    chk("er_last_data", last_data, 3'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("er_after_xfers", xfers, xf0 + 1);
    chk("er_after_x", cur_x, nx);

    // Held clear request: 64 back-to-back writes, buttons ignored, then no repeat.
    xf0 = xfers;
    pen = 2'b11; btn = B_R; rdy = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 64; a++) begin
      chk($sformatf("clr%0d_busy", a), busy, 1'b1);
      chk($sformatf("clr%0d_addr", a), wr_if.wr_addr, a[5:0]);
      chk($sformatf("clr%0d_wr_en", a), wr_if.wr_en, 1'b1);
      chk($sformatf("clr%0d_data", a), wr_if.wr_data, 3'd0);
      @(posedge clk); #1;
    end
    chk("clr_end_busy", busy, 1'b0);
    chk("clr_end_wr_en", wr_if.wr_en, 1'b0);
    chk("clr_xfers", xfers, xf0 + 64);
    chk("clr_x", cur_x, nx);
    chk("clr_y", cur_y, cy);
    repeat (10) @(posedge clk);
    #1;
    chk("clr_hold_xfers", xfers, xf0 + 64);
    chk("clr_hold_busy", busy, 1'b0);
    pen = 2'b00; btn = B_NONE;
    @(posedge clk); #1;

    // Reset in the middle of a clear abandons it.
    pen = 2'b11;
    @(posedge clk); #1;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_clr_addr", wr_if.wr_addr, 6'd20);
    chk("mid_clr_busy", busy, 1'b1);
    reset = 1'b1; pen = 2'b00;
    @(posedge clk); #1;
    chk("rst2_wr_en", wr_if.wr_en, 1'b0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_x", cur_x, 3'd4);
    chk("rst2_y", cur_y, 3'd4);
    chk("rst2_addr", wr_if.wr_addr, 6'd0);
    xf0 = xfers;
    reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_xfers", xfers, xf0);
    chk("post_rst_wr_en", wr_if.wr_en, 1'b0);
    chk("post_rst_x", cur_x, 3'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
